uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter between NUM_REQ byte-stream requesters: monitor read responses, telemetry and event streams. Arbitration is round-robin at packet granularity, so a granted requester keeps the transmitter until it has sent its last byte. The block drives the transmitter's write and data inputs, paces on the transmitter's busy flag, and aborts stalled packets with a watchdog. It sits between the monitor/other sources and uart_tx, in the oversampled baud clock domain.

---
 rtl/uart_tx_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 516 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter that shares one uart_tx between NUM_REQ byte streams.
// Paces on tx_busy and drops packets whose requester stalls or whose transmitter never answers.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_BITS     = 8,
  parameter int BUSY_TIMEOUT  = 64,
  parameter int STALL_TIMEOUT = 4096
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_BITS-1:0]  req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            grant,
  input  logic                          tx_pause,
  input  logic                          tx_busy,
  output logic                          tx_write,
  output logic [DATA_BITS-1:0]          tx_byte,
  output logic                          err_busy_timeout,
  output logic                          err_stall_abort
);

  localparam int PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TIMER_MAX = (BUSY_TIMEOUT > STALL_TIMEOUT) ? BUSY_TIMEOUT : STALL_TIMEOUT;
  localparam int TMR_W     = (TIMER_MAX > 2) ? $clog2(TIMER_MAX) : 1;

  localparam logic [TMR_W-1:0] BUSY_LIMIT  = TMR_W'(BUSY_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] STALL_LIMIT = TMR_W'(STALL_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TIMER_SAT   = '1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t               r_state,    w_stateNext;
  logic [PTR_W-1:0]     r_ptr,      w_ptrNext;
  logic [PTR_W-1:0]     r_g,        w_gNext;
  logic                 r_lastQ,    w_lastQNext;
  logic [TMR_W-1:0]     r_timer,    w_timerNext;
  logic [NUM_REQ-1:0]   r_grant,    w_grantNext;
  logic                 r_txWrite,  w_txWriteNext;
  logic [DATA_BITS-1:0] r_txByte,   w_txByteNext;
  logic                 r_errBusy,  w_errBusyNext;
  logic                 r_errStall, w_errStallNext;

  logic [DATA_BITS-1:0] w_reqBytes [NUM_REQ];
  logic                 w_curValid;
  logic                 w_curLast;
  logic [DATA_BITS-1:0] w_curData;
  logic                 w_transfer;
  logic                 w_pickFound;
  logic [PTR_W-1:0]     w_pickIdx;
  logic [PTR_W-1:0]     w_candIdx;
  logic [NUM_REQ-1:0]   w_pickOneHot;
  logic [TMR_W-1:0]     w_timerInc;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
    assign w_reqBytes[i] = req_data[i*DATA_BITS +: DATA_BITS];
  end

  assign w_curValid   = req_valid[r_g];
  assign w_curLast    = req_last[r_g];
  assign w_curData    = w_reqBytes[r_g];
  assign w_transfer   = (r_state == SEND) & w_curValid & ~tx_pause & ~tx_busy & ~reset;
  assign w_pickOneHot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pickIdx;
  assign w_timerInc   = (r_timer == TIMER_SAT) ? r_timer : r_timer + TMR_W'(1);

  // Scan from farthest to nearest after ptr so the nearest valid requester wins.
  always_comb begin
    w_pickFound = 1'b0;
    w_pickIdx   = '0;
    w_candIdx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_candIdx = PTR_W'((int'(r_ptr) + k) % NUM_REQ);
      if (req_valid[w_candIdx]) begin
        w_pickFound = 1'b1;
        w_pickIdx   = w_candIdx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if ((r_state == SEND) && !reset) begin
      req_ready[r_g] = w_curValid & ~tx_pause & ~tx_busy;
    end
  end

  always_comb begin
    w_stateNext    = r_state;
    w_ptrNext      = r_ptr;
    w_gNext        = r_g;
    w_lastQNext    = r_lastQ;
    w_timerNext    = r_timer;
    w_grantNext    = r_grant;
    w_txWriteNext  = r_txWrite;
    w_txByteNext   = r_txByte;
    w_errBusyNext  = 1'b0;
    w_errStallNext = 1'b0;
    case (r_state)
      IDLE: begin
        w_grantNext   = '0;
        w_txWriteNext = 1'b0;
        if (w_pickFound) begin
          w_gNext     = w_pickIdx;
          w_grantNext = w_pickOneHot;
          w_timerNext = '0;
          w_stateNext = SEND;
        end
      end
      SEND: begin
        if (w_transfer) begin
          w_txByteNext  = w_curData;
          w_txWriteNext = 1'b1;
          w_lastQNext   = w_curLast;
          w_timerNext   = '0;
          w_stateNext   = WAIT_BUSY;
        end else if (!w_curValid) begin
          // Only a silent requester counts toward the stall; pause/busy back-pressure does not.
          if (r_timer >= STALL_LIMIT) begin
            w_errStallNext = 1'b1;
            w_ptrNext      = r_g;
            w_grantNext    = '0;
            w_stateNext    = IDLE;
          end else begin
            w_timerNext = w_timerInc;
          end
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          w_txWriteNext = 1'b0;
          w_timerNext   = '0;
          w_stateNext   = WAIT_DONE;
        end else if (r_timer >= BUSY_LIMIT) begin
          w_errBusyNext = 1'b1;
          w_txWriteNext = 1'b0;
          w_ptrNext     = r_g;
          w_grantNext   = '0;
          w_stateNext   = IDLE;
        end else begin
          w_timerNext = w_timerInc;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          w_timerNext = '0;
          if (r_lastQ) begin
            w_ptrNext   = r_g;
            w_grantNext = '0;
            w_stateNext = IDLE;
          end else begin
            w_stateNext = SEND;
          end
        end
      end
      default: begin
        w_grantNext   = '0;
        w_txWriteNext = 1'b0;
        w_stateNext   = IDLE;
      end
    endcase
  end

  // ptr resets to the last index so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ptr      <= PTR_W'(NUM_REQ - 1);
      r_g        <= '0;
      r_lastQ    <= 1'b0;
      r_timer    <= '0;
      r_grant    <= '0;
      r_txWrite  <= 1'b0;
      r_txByte   <= '0;
      r_errBusy  <= 1'b0;
      r_errStall <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_ptr      <= w_ptrNext;
      r_g        <= w_gNext;
      r_lastQ    <= w_lastQNext;
      r_timer    <= w_timerNext;
      r_grant    <= w_grantNext;
      r_txWrite  <= w_txWriteNext;
      r_txByte   <= w_txByteNext;
      r_errBusy  <= w_errBusyNext;
      r_errStall <= w_errStallNext;
    end
  end

  assign grant            = r_grant;
  assign tx_write         = r_txWrite;
  assign tx_byte          = r_txByte;
  assign err_busy_timeout = r_errBusy;
  assign err_stall_abort  = r_errStall;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester byte queues feed the DUT, a uart_tx
// model answers tx_write, and the expected (owner, byte) order is queued by each scenario.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ       = 4;
  localparam int DATA_BITS     = 8;
  localparam int BUSY_TIMEOUT  = 64;
  localparam int STALL_TIMEOUT = 16;
  localparam int BUSY_CLKS     = 11;

  typedef struct {
    int                   idx;
    logic [DATA_BITS-1:0] data;
  } expect_t;

  logic                         clk;
  logic                         reset;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_last;
  logic [NUM_REQ*DATA_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0]           grant;
  logic                         tx_pause;
  logic                         tx_busy;
  logic                         tx_write;
  logic [DATA_BITS-1:0]         tx_byte;
  logic                         err_busy_timeout;
  logic                         err_stall_abort;

  logic [DATA_BITS:0] reqQ [NUM_REQ][$];
  expect_t            sbQ[$];
  bit                 pendAcc [NUM_REQ];
  bit                 modelEnable;
  int                 busyCnt;
  int                 vectors;
  int                 miscompares;

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .DATA_BITS    (DATA_BITS),
    .BUSY_TIMEOUT (BUSY_TIMEOUT),
    .STALL_TIMEOUT(STALL_TIMEOUT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_last        (req_last),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .grant           (grant),
    .tx_pause        (tx_pause),
    .tx_busy         (tx_busy),
    .tx_write        (tx_write),
    .tx_byte         (tx_byte),
    .err_busy_timeout(err_busy_timeout),
    .err_stall_abort (err_stall_abort)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "[TB] global timeout");
  end

  // Requester drivers: present queue heads at negedge, note handshakes just before the posedge.
  initial begin
    logic [DATA_BITS:0] head;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (pendAcc[i] && reqQ[i].size() > 0) void'(reqQ[i].pop_front());
        pendAcc[i] = 1'b0;
        if (reqQ[i].size() > 0) begin
          head = reqQ[i][0];
          req_valid[i] = 1'b1;
          req_last[i]  = head[DATA_BITS];
          req_data[i*DATA_BITS +: DATA_BITS] = head[DATA_BITS-1:0];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
          req_data[i*DATA_BITS +: DATA_BITS] = '0;
        end
      end
      #1;
      for (int i = 0; i < NUM_REQ; i++) pendAcc[i] = req_valid[i] & req_ready[i] & ~reset;
    end
  end

  // uart_tx model: a write seen just after a posedge makes busy high for BUSY_CLKS cycles.
  initial begin
    tx_busy = 1'b0;
    busyCnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        tx_busy = 1'b0;
        busyCnt = 0;
      end else if (tx_busy) begin
        if (busyCnt <= 1) begin
          tx_busy = 1'b0;
          busyCnt = 0;
        end else begin
          busyCnt = busyCnt - 1;
        end
      end else if (modelEnable && tx_write) begin
        tx_busy = 1'b1;
        busyCnt = BUSY_CLKS;
      end
    end
  end

  // Output monitor: each tx_write rise pops one expected (owner, byte) pair.
  initial begin
    bit                 prevWrite;
    expect_t            e;
    logic [NUM_REQ-1:0] expGrant;
    prevWrite = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (tx_write && !prevWrite) begin
          vectors++;
          if (sbQ.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL unexpected_write: tx_byte=%h grant=%b, nothing expected", tx_byte, grant);
          end else begin
            e = sbQ.pop_front();
            expGrant = '0;
            expGrant[e.idx] = 1'b1;
            if (tx_byte !== e.data) begin
              miscompares++;
              $display("[TB] FAIL tx_byte: got %h expected %h", tx_byte, e.data);
            end
            vectors++;
            if (grant !== expGrant) begin
              miscompares++;
              $display("[TB] FAIL write_owner: grant %b expected %b (byte %h)", grant, expGrant, e.data);
            end
          end
        end
        if (!tx_write && prevWrite && modelEnable) begin
          vectors++;
          if (tx_busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL write_held_until_busy: tx_busy=%b at write drop, expected 1", tx_busy);
          end
        end
      end
      prevWrite = tx_write;
    end
  end

  task automatic sendByte(input int idx, input logic last, input logic [DATA_BITS-1:0] d);
    reqQ[idx].push_back({last, d});
  endtask

  task automatic expectByte(input int idx, input logic [DATA_BITS-1:0] d);
    expect_t e;
    e.idx  = idx;
    e.data = d;
    sbQ.push_back(e);
  endtask

  function automatic bit allReqEmpty();
    for (int i = 0; i < NUM_REQ; i++) if (reqQ[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic waitIdle(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      #2;
      if (sbQ.size() == 0 && allReqEmpty() && grant == '0 && !tx_write && !tx_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({grant, req_ready} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_grant_ready: grant=%b ready=%b expected 0", grant, req_ready);
    end
    vectors++;
    if ({tx_write, tx_byte} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_tx: write=%b byte=%h expected 0", tx_write, tx_byte);
    end
    vectors++;
    if ({err_busy_timeout, err_stall_abort} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL reset_errs: %b%b expected 00", err_busy_timeout, err_stall_abort);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_packet();
    bit ok;
    @(posedge clk);
    #2;
    sendByte(0, 1'b0, 8'hA5);
    sendByte(0, 1'b1, 8'h5A);
    expectByte(0, 8'hA5);
    expectByte(0, 8'h5A);
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (grant !== 4'b0001) begin
      miscompares++;
      $display("[TB] FAIL grant_latency: grant=%b expected 0001", grant);
    end
    vectors++;
    if (tx_write !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL write_too_early: tx_write=%b expected 0", tx_write);
    end
    @(negedge clk);
    vectors++;
    if (tx_write !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL write_latency: tx_write=%b expected 1", tx_write);
    end
    waitIdle(300, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL single_packet_drain: pending=%0d expected 0, grant=%b", sbQ.size(), grant);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #2;
    sendByte(0, 1'b1, 8'h10);
    sendByte(0, 1'b1, 8'h14);
    sendByte(1, 1'b1, 8'h11);
    sendByte(2, 1'b1, 8'h12);
    sendByte(3, 1'b1, 8'h13);
    expectByte(0, 8'h10);
    expectByte(1, 8'h11);
    expectByte(2, 8'h12);
    expectByte(3, 8'h13);
    expectByte(0, 8'h14);
    waitIdle(600, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL round_robin_drain: pending=%0d expected 0", sbQ.size());
    end
  endtask

  task automatic test_packet_lock();
    bit ok;
    @(posedge clk);
    #2;
    sendByte(0, 1'b1, 8'h20);
    sendByte(1, 1'b0, 8'h31);
    sendByte(1, 1'b0, 8'h32);
    sendByte(1, 1'b1, 8'h33);
    sendByte(2, 1'b1, 8'h22);
    expectByte(1, 8'h31);
    expectByte(1, 8'h32);
    expectByte(1, 8'h33);
    expectByte(2, 8'h22);
    expectByte(0, 8'h20);
    waitIdle(600, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL packet_lock_drain: pending=%0d expected 0", sbQ.size());
    end
  endtask

  task automatic test_pause();
    bit ok;
    bit found;
    bit prev;
    bit stallSeen;
    int rises;
    @(posedge clk);
    #2;
    sendByte(1, 1'b0, 8'hC1);
    sendByte(1, 1'b0, 8'hC2);
    sendByte(1, 1'b1, 8'hC3);
    expectByte(1, 8'hC1);
    expectByte(1, 8'hC2);
    expectByte(1, 8'hC3);
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (tx_write) begin
        found = 1'b1;
        break;
      end
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("[TB] FAIL pause_first_write: no tx_write within 100 cycles, expected one");
    end
    tx_pause  = 1'b1;
    rises     = 0;
    prev      = 1'b1;
    stallSeen = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (tx_write && !prev) rises++;
      prev = tx_write;
      if (err_stall_abort) stallSeen = 1'b1;
    end
    vectors++;
    if (rises != 0) begin
      miscompares++;
      $display("[TB] FAIL pause_blocks_write: %0d writes during pause, expected 0", rises);
    end
    vectors++;
    if (stallSeen) begin
      miscompares++;
      $display("[TB] FAIL pause_no_stall: err_stall_abort seen=1 expected 0");
    end
    vectors++;
    if (grant !== 4'b0010) begin
      miscompares++;
      $display("[TB] FAIL pause_grant_held: grant=%b expected 0010", grant);
    end
    tx_pause = 1'b0;
    waitIdle(300, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL pause_resume_drain: pending=%0d expected 0", sbQ.size());
    end
  endtask

  task automatic test_stall_abort();
    bit ok;
    bit found;
    int at;
    @(posedge clk);
    #2;
    sendByte(2, 1'b0, 8'h42);
    sendByte(3, 1'b1, 8'h53);
    expectByte(2, 8'h42);
    expectByte(3, 8'h53);
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (tx_write && tx_busy) begin
        found = 1'b1;
        break;
      end
    end
    for (int c = 0; c < 100 && found; c++) begin
      if (!tx_busy) break;
      @(negedge clk);
    end
    vectors++;
    if (!found || tx_busy) begin
      miscompares++;
      $display("[TB] FAIL stall_first_byte: found=%b busy=%b, expected byte sent and busy 0", found, tx_busy);
    end
    at = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (err_stall_abort) begin
        at = c;
        break;
      end
    end
    vectors++;
    if (at != 17) begin
      miscompares++;
      $display("[TB] FAIL stall_abort_time: pulse at %0d cycles after busy fall, expected 17", at);
    end
    vectors++;
    if (grant !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL stall_grant_release: grant=%b expected 0000", grant);
    end
    @(negedge clk);
    vectors++;
    if ({err_stall_abort, grant} !== {1'b0, 4'b1000}) begin
      miscompares++;
      $display("[TB] FAIL stall_next_owner: err=%b grant=%b expected err 0 grant 1000", err_stall_abort, grant);
    end
    waitIdle(300, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL stall_drain: pending=%0d expected 0", sbQ.size());
    end
  endtask

  task automatic test_busy_timeout();
    bit ok;
    bit found;
    bit writeAt63;
    int at;
    modelEnable = 1'b0;
    @(posedge clk);
    #2;
    sendByte(0, 1'b1, 8'h66);
    expectByte(0, 8'h66);
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (tx_write) begin
        found = 1'b1;
        break;
      end
    end
    at = -1;
    writeAt63 = 1'b0;
    for (int c = 1; c <= 100 && found; c++) begin
      @(negedge clk);
      if (c == 63) writeAt63 = tx_write;
      if (err_busy_timeout) begin
        at = c;
        break;
      end
    end
    vectors++;
    if (at != BUSY_TIMEOUT) begin
      miscompares++;
      $display("[TB] FAIL busy_timeout_time: pulse at %0d, expected %0d", at, BUSY_TIMEOUT);
    end
    vectors++;
    if ({writeAt63, tx_write, grant} !== {1'b1, 1'b0, 4'b0000}) begin
      miscompares++;
      $display("[TB] FAIL busy_timeout_outputs: write63=%b write=%b grant=%b expected 1 0 0000", writeAt63, tx_write, grant);
    end
    waitIdle(100, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL busy_timeout_idle: pending=%0d expected 0", sbQ.size());
    end
    modelEnable = 1'b1;
  endtask

  task automatic test_reset_mid_packet();
    bit found;
    @(posedge clk);
    #2;
    sendByte(1, 1'b0, 8'h77);
    sendByte(1, 1'b1, 8'h78);
    expectByte(1, 8'h77);
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (tx_busy && !tx_write && grant != '0) begin
        found = 1'b1;
        break;
      end
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("[TB] FAIL reset_reach_wait_done: not reached within 100 cycles, expected reached");
    end
    reset = 1'b1;
    reqQ[1].delete();
    @(negedge clk);
    vectors++;
    if ({grant, req_ready, tx_write, tx_byte, err_busy_timeout, err_stall_abort} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_packet: grant=%b ready=%b write=%b byte=%h errs=%b%b expected all 0",
               grant, req_ready, tx_write, tx_byte, err_busy_timeout, err_stall_abort);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (grant !== '0 || sbQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL reset_abandon: grant=%b pending=%0d expected 0000 and 0", grant, sbQ.size());
    end
  endtask

  initial begin
    reset       = 1'b1;
    tx_pause    = 1'b0;
    modelEnable = 1'b1;
    vectors     = 0;
    miscompares = 0;
    $display("[TB] uart_tx_arbiter bench start");
    test_reset();
    test_single_packet();
    test_round_robin();
    test_packet_lock();
    test_pause();
    test_stall_abort();
    test_busy_timeout();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
